// File: rtl/ar_mux_41.sv
// Registered 4:1 lane multiplexer with enable. The chosen lane appears on y one
// clock after it is sampled; y and y_valid are forced low whenever enable is low.
module ar_mux_41 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*WIDTH-1:0] a,
    input  logic [1:0]         sel,
    input  logic               enable,
    output logic [WIDTH-1:0]   y,
    output logic               y_valid
);

    logic [WIDTH-1:0] lane_s;
    logic [WIDTH-1:0] y_r;
    logic             y_valid_r;

    // Lane selection; only the addressed slice reaches lane_s, so unknowns on other lanes stay out of y.
    always_comb begin
        lane_s = '0;
        case (sel)
            2'd0:    lane_s = a[0*WIDTH +: WIDTH];
            2'd1:    lane_s = a[1*WIDTH +: WIDTH];
            2'd2:    lane_s = a[2*WIDTH +: WIDTH];
            2'd3:    lane_s = a[3*WIDTH +: WIDTH];
            default: lane_s = '0;
        endcase
    end

    // Output register: reset and disable both clear the lane rather than holding it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end else if (enable) begin
            y_r       <= lane_s;
            y_valid_r <= 1'b1;
        end else begin
            y_r       <= '0;
            y_valid_r <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;

endmodule

// File: tb/tb_ar_mux_41.sv
// Self-checking bench for ar_mux_41: a WIDTH=1 and a WIDTH=8 instance share
// control inputs and are compared against a shift-and-mask reference model.
module tb_ar_mux_41;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sel;
    logic        enable;
    logic [3:0]  a1;
    logic [31:0] a8;
    logic [0:0]  y1;
    logic [7:0]  y8;
    logic        v1;
    logic        v8;

    int errors = 0;
    int checks = 0;

    logic [7:0] e1;
    logic [7:0] e8;
    logic       ev;

    ar_mux_41 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .sel(sel), .enable(enable),
        .y(y1), .y_valid(v1)
    );

    ar_mux_41 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .sel(sel), .enable(enable),
        .y(y8), .y_valid(v8)
    );

    always #5 clk = ~clk;

    // Reference: lane s of a is the w-bit field starting at bit s*w; zero when reset or disabled.
    function automatic logic [7:0] ref_lane(input logic r, input logic en,
                                            input logic [31:0] av, input logic [1:0] s,
                                            input int w);
        logic [31:0] tmp;
        logic [31:0] mask;
        if (!r || !en) return 8'd0;
        tmp  = av >> (32'(s) * w);
        mask = (32'd1 << w) - 32'd1;
        return 8'(tmp & mask);
    endfunction

    // Record expectations from the inputs about to be sampled, then cross the edge.
    task automatic tick();
        e1 = ref_lane(rst_n, enable, {28'd0, a1}, sel, 1);
        e8 = ref_lane(rst_n, enable, a8, sel, 8);
        ev = rst_n & enable;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; a1 = 4'b1111; a8 = 32'hFFFF_FFFF; sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (y1 !== 1'b0 || v1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_w1: y=%0b y_valid=%0b expected y=0 y_valid=0", y1, v1);
            end
            checks++;
            if (y8 !== 8'h00 || v8 !== 1'b0) begin
                errors++;
                $display("FAIL reset_w8: y=%h y_valid=%0b expected y=00 y_valid=0", y8, v8);
            end
        end
    endtask

    task automatic test_lane_select();
        logic [1:0] sels [3];
        logic       want [3];
        sels[0] = 2'd1; sels[1] = 2'd0; sels[2] = 2'd2;
        want[0] = 1'b0; want[1] = 1'b1; want[2] = 1'b1;
        rst_n = 1'b1; enable = 1'b1; a1 = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            sel = sels[i];
            tick();
            checks++;
            if (y1 !== want[i] || y1 !== e1[0] || v1 !== 1'b1) begin
                errors++;
                $display("FAIL lane_select sel=%0d: y=%0b y_valid=%0b expected y=%0b y_valid=1",
                         sels[i], y1, v1, want[i]);
            end
        end
    endtask

    task automatic test_sweep();
        rst_n = 1'b1; enable = 1'b1; a1 = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            tick();
            checks++;
            if (y1 !== 1'(i % 2) || v1 !== 1'b1) begin
                errors++;
                $display("FAIL sweep sel=%0d: y=%0b y_valid=%0b expected y=%0d y_valid=1",
                         i, y1, v1, i % 2);
            end
        end
    endtask

    task automatic test_disable();
        rst_n = 1'b1; enable = 1'b1; a1 = 4'b0010; sel = 2'd1;
        tick();
        checks++;
        if (y1 !== 1'b1 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL disable_pre: y=%0b y_valid=%0b expected y=1 y_valid=1", y1, v1);
        end
        enable = 1'b0;
        tick();
        checks++;
        if (y1 !== 1'b0 || v1 !== 1'b0 || y8 !== 8'h00 || v8 !== 1'b0) begin
            errors++;
            $display("FAIL disable_low: y1=%0b v1=%0b y8=%h v8=%0b expected all zero",
                     y1, v1, y8, v8);
        end
        enable = 1'b1;
        tick();
        checks++;
        if (y1 !== 1'b1 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL disable_resume: y=%0b y_valid=%0b expected y=1 y_valid=1", y1, v1);
        end
    endtask

    task automatic test_wide();
        rst_n = 1'b1; enable = 1'b1; a8 = 32'hDEAD_BEEF;
        sel = 2'd3;
        tick();
        checks++;
        if (y8 !== 8'hDE || v8 !== 1'b1) begin
            errors++;
            $display("FAIL wide_sel3: y=%h y_valid=%0b expected y=de y_valid=1", y8, v8);
        end
        sel = 2'd0;
        tick();
        checks++;
        if (y8 !== 8'hEF || v8 !== 1'b1) begin
            errors++;
            $display("FAIL wide_sel0: y=%h y_valid=%0b expected y=ef y_valid=1", y8, v8);
        end
        for (int s = 1; s < 3; s++) begin
            sel = 2'(s);
            tick();
            checks++;
            if (y8 !== e8 || v8 !== 1'b1) begin
                errors++;
                $display("FAIL wide_sel%0d: y=%h y_valid=%0b expected y=%h y_valid=1",
                         s, y8, v8, e8);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b1; enable = 1'b1; a8 = 32'h1234_5678; sel = 2'd2; a1 = 4'b0100;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (y8 !== 8'h00 || v8 !== 1'b0 || y1 !== 1'b0 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: y8=%h v8=%0b y1=%0b v1=%0b expected all zero",
                     y8, v8, y1, v1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (y8 !== 8'h34 || v8 !== 1'b1 || y1 !== 1'b1 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: y8=%h v8=%0b y1=%0b v1=%0b expected y8=34 v8=1 y1=1 v1=1",
                     y8, v8, y1, v1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst_n  = ($urandom_range(0, 15) != 0);
            enable = ($urandom_range(0, 3) != 0);
            sel    = 2'($urandom_range(0, 3));
            a8     = $urandom;
            a1     = 4'bxxxx;
            a1[sel] = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (y1 !== e1[0] || v1 !== ev) begin
                errors++;
                $display("FAIL random_w1 #%0d: y=%0b y_valid=%0b expected y=%0b y_valid=%0b",
                         i, y1, v1, e1[0], ev);
            end
            checks++;
            if (y8 !== e8 || v8 !== ev) begin
                errors++;
                $display("FAIL random_w8 #%0d: y=%h y_valid=%0b expected y=%h y_valid=%0b",
                         i, y8, v8, e8, ev);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; sel = 2'd0; a1 = 4'd0; a8 = 32'd0;
        test_reset();
        test_lane_select();
        test_sweep();
        test_disable();
        test_wide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
